// File: rtl/ftdi_uart_rx_pkg.sv
// ftdi_pkg: definitions shared by the FTDI UART receiver and transmitter.
// FSM state encodings, sample-increment helper, vote and parity helpers.
package ftdi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } ftdi_state_e;

  // Accumulator increment giving `oversample` carries per bit; 64-bit so the shift cannot overflow.
  function automatic logic [63:0] sample_inc(input logic [63:0] freq, input logic [63:0] baud,
                                             input logic [63:0] oversample, input int unsigned acc_w);
    return ((baud * oversample) << acc_w) / freq;
  endfunction

  // Two-out-of-three majority of the samples around the bit centre.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Even-parity bit of a byte (value that makes the total count of ones even).
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/ftdi_uart_rx_if.sv
// ftdi_uart_rx_if: consumer-side interface of the FTDI UART receiver.
// master = receiver (produces bytes and status), slave = downstream consumer.
interface ftdi_uart_rx_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ack;
  logic       framing_error;
  logic       overrun;
  logic       parity_error;
  logic       busy;

  modport master (
    output data, data_valid, framing_error, overrun, parity_error, busy,
    input  data_ack
  );

  modport slave (
    input  data, data_valid, framing_error, overrun, parity_error, busy,
    output data_ack
  );
endinterface

// File: rtl/ftdi_uart_rx_baud_gen.sv
// ftdi_baud_gen: fractional phase accumulator; tick is the carry out of each add.
// Held at zero while clr is high so the first tick lands a fixed time after a start edge.
module ftdi_baud_gen #(
  parameter int unsigned         ACC_W = 32,
  parameter logic [ACC_W-1:0]    INC   = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum_s;

  // Next accumulator value: clear dominates, otherwise add while enabled.
  always_comb begin
    sum_s = {1'b0, acc_q} + {1'b0, INC};
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum_s[ACC_W-1:0];
    end else begin
      acc_d = acc_q;
    end
  end

  assign tick = en & ~clr & sum_s[ACC_W];

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/ftdi_uart_rx.sv
// ftdi_uart_rx: UART receiver for the FTDI link (FTDI chip -> FPGA), 8N1 frames.
// Define FTDI_RX_PARITY_EN for 8E1 frames with an even-parity check.
// Synchroniser, tick-spaced 3-sample vote, receive FSM and valid/ack holding register.
module ftdi_uart_rx
  import ftdi_pkg::*;
#(
  parameter int unsigned FREQUENCY     = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115_200,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned BAUD_RG_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           FTDI_TX,
  ftdi_uart_rx_if.master rx_if
);
  localparam logic [63:0] SAMPLE_INC =
    sample_inc(64'(FREQUENCY), 64'(BAUD_RATE), 64'(OVERSAMPLE), BAUD_RG_WIDTH);
  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  // The vote resolves on the tick after the centre sample, once centre+1 is in the window.
  localparam logic [CNT_W-1:0] VOTE_CNT = CNT_W'(OVERSAMPLE / 2);

  logic [1:0]       sync_q, sync_d;
  logic             line_prev_q, line_prev_d;
  logic [1:0]       hist_q, hist_d;
  logic             line_s, fall_s, tick_s, vote_now_s, vote_s;
  ftdi_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q, data_q;
  logic             data_valid_q, framing_error_q, overrun_q, busy_q;
`ifdef FTDI_RX_PARITY_EN
  logic             parity_bad_q, parity_error_q;
`endif

  assign line_s     = sync_q[1];
  assign fall_s     = line_prev_q & ~line_s;
  assign vote_now_s = tick_s & (cnt_q == VOTE_CNT);
  assign vote_s     = maj3({hist_q, line_s});

  ftdi_baud_gen #(
    .ACC_W (BAUD_RG_WIDTH),
    .INC   (SAMPLE_INC[BAUD_RG_WIDTH-1:0])
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != ST_IDLE),
    .clr   (state_q == ST_IDLE),
    .tick  (tick_s)
  );

  // Next values for the synchroniser, the edge detector and the per-tick sample history.
  always_comb begin
    sync_d      = {sync_q[0], FTDI_TX};
    line_prev_d = line_s;
    if (tick_s) begin
      hist_d = {hist_q[0], line_s};
    end else begin
      hist_d = hist_q;
    end
  end

  // Synchroniser and history registers; idle-high after reset so no false start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= 2'b11;
      line_prev_q <= 1'b1;
      hist_q      <= 2'b11;
    end else begin
      sync_q      <= sync_d;
      line_prev_q <= line_prev_d;
      hist_q      <= hist_d;
    end
  end

  // Receive FSM with sample counter, shift register, output register and handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= 3'd0;
      shift_q         <= 8'd0;
      data_q          <= 8'd0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
      busy_q          <= 1'b0;
`ifdef FTDI_RX_PARITY_EN
      parity_bad_q    <= 1'b0;
      parity_error_q  <= 1'b0;
`endif
    end else begin
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
`ifdef FTDI_RX_PARITY_EN
      parity_error_q  <= 1'b0;
`endif
      if (state_q == ST_IDLE) begin
        cnt_q <= '0;
      end else if (tick_s) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // Ack clears the holding register; a byte completing this cycle overrides below.
      if (rx_if.data_ack && data_valid_q) begin
        data_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          // Needs a real 1->0 transition, so a held-low (break) line never retriggers.
          if (fall_s) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (vote_now_s) begin
            if (vote_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= ST_DATA;
              bit_idx_q <= 3'd0;
            end
          end
        end
        ST_DATA: begin
          if (vote_now_s) begin
            shift_q <= {vote_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
`ifdef FTDI_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
`ifdef FTDI_RX_PARITY_EN
        ST_PARITY: begin
          if (vote_now_s) begin
            parity_bad_q <= (vote_s != even_parity(shift_q));
            state_q      <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (vote_now_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (vote_s) begin
              data_q       <= shift_q;
              data_valid_q <= 1'b1;
              overrun_q    <= data_valid_q & ~rx_if.data_ack;
            end else begin
              framing_error_q <= 1'b1;
            end
`ifdef FTDI_RX_PARITY_EN
            parity_error_q <= parity_bad_q;
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.data          = data_q;
  assign rx_if.data_valid    = data_valid_q;
  assign rx_if.framing_error = framing_error_q;
  assign rx_if.overrun       = overrun_q;
  assign rx_if.busy          = busy_q;
`ifdef FTDI_RX_PARITY_EN
  assign rx_if.parity_error  = parity_error_q;
`else
  assign rx_if.parity_error  = 1'b0;
`endif
endmodule

// File: tb/tb_ftdi_uart_rx.sv
// tb_ftdi_uart_rx: directed + randomized bench for ftdi_uart_rx with a frame-level reference model.
// Sim params: FREQUENCY=32, BAUD_RATE=1, OVERSAMPLE=16 -> one bit = 32 clk.
module tb_ftdi_uart_rx;
`ifdef FTDI_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  localparam int BIT_CLK  = 32;
  localparam int PRE_STOP = PARITY_ON ? 10 : 9;          // start + data (+ parity)
  localparam int LAT      = PRE_STOP * BIT_CLK + BIT_CLK / 2; // wire start edge -> stop centre
  localparam int LAT_TOL  = 12;

  logic clk = 1'b0;
  logic reset;
  logic FTDI_TX;
  ftdi_uart_rx_if rx_if();

  ftdi_uart_rx #(
    .FREQUENCY(32), .BAUD_RATE(1), .OVERSAMPLE(16), .BAUD_RG_WIDTH(32)
  ) dut (
    .clk(clk), .reset(reset), .FTDI_TX(FTDI_TX), .rx_if(rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0, passes = 0;
  int fe_hi = 0, ov_hi = 0, pe_hi = 0, busy_hi = 0;
  int rise_cyc = 0, fall_cyc = 0, ack_cyc = 0, frame_cyc = 0;
  logic prev_valid = 1'b0;

  // Reference model state (frame level).
  logic [7:0] exp_data;
  logic       exp_valid;
  int         exp_fe = 0, exp_ov = 0, exp_pe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor on the falling edge: pulse widths, busy time, valid edges.
  always @(negedge clk) begin
    if (rx_if.framing_error === 1'b1) fe_hi++;
    if (rx_if.overrun === 1'b1) ov_hi++;
    if (rx_if.parity_error === 1'b1) pe_hi++;
    if (rx_if.busy === 1'b1) busy_hi++;
    if (rx_if.data_valid === 1'b1 && prev_valid === 1'b0) rise_cyc = cyc;
    if (rx_if.data_valid === 1'b0 && prev_valid === 1'b1) fall_cyc = cyc;
    prev_valid = rx_if.data_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a falling edge; leaves the line at the stop level.
  // ack_k >= 0 pulses data_ack for one clk at that clk index inside the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_b, input int ack_k);
    logic [9:0] bits;
    bits = {par_b, b, 1'b0};
    frame_cyc = cyc;
    for (int i = 0; i < PRE_STOP; i++) begin
      FTDI_TX = bits[i];
      tick_n(BIT_CLK);
    end
    FTDI_TX = stop_b;
    for (int k = 0; k < BIT_CLK; k++) begin
      if (k == ack_k) begin
        rx_if.data_ack = 1'b1;
        ack_cyc = cyc;
      end else begin
        rx_if.data_ack = 1'b0;
      end
      @(negedge clk);
    end
    rx_if.data_ack = 1'b0;
  endtask

  task automatic gap();
    FTDI_TX = 1'b1;
    tick_n(6);
  endtask

  // Model: outcome of one frame. acked = consumer acks after completion; ack_same = ack on the completion clk.
  task automatic expect_frame(input logic [7:0] b, input logic stop_b, input logic par_b,
                              input bit acked, input bit ack_same);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    exp_pe += (PARITY_ON && (int'(par_b) != (ones % 2))) ? 1 : 0;
    if (stop_b) begin
      if (exp_valid && !ack_same) exp_ov++;
      exp_data  = b;
      exp_valid = !acked;
    end else begin
      exp_fe++;
      if (acked) exp_valid = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".data"},  32'(rx_if.data), 32'(exp_data));
    check({tag, ".valid"}, 32'(rx_if.data_valid), 32'(exp_valid));
    check({tag, ".fe"},    32'(fe_hi), 32'(exp_fe));
    check({tag, ".ov"},    32'(ov_hi), 32'(exp_ov));
    check({tag, ".pe"},    32'(pe_hi), 32'(exp_pe));
  endtask

  function automatic logic good_par(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2) == 1;
  endfunction

  initial begin
    int lat_meas, sim_k, b0, diff;
    logic [7:0] rb;
    logic rs, rp;
    bit ra;

    FTDI_TX = 1'b1;
    rx_if.data_ack = 1'b0;
    reset = 1'b1;
    exp_data = 8'h00;
    exp_valid = 1'b0;
    tick_n(4);
    check("rst.busy", 32'(rx_if.busy), 32'd0);
    reset = 1'b0;
    tick_n(4);
    check_state("rst");
    check("rst.busy2", 32'(rx_if.busy), 32'd0);

    // 0xA5, acked after valid
    send_frame(8'hA5, 1'b1, good_par(8'hA5), 26);
    expect_frame(8'hA5, 1'b1, good_par(8'hA5), 1'b1, 1'b0);
    lat_meas = rise_cyc - frame_cyc;
    check("a5.lat_window", 32'((lat_meas >= LAT - LAT_TOL) && (lat_meas <= LAT + LAT_TOL)), 32'd1);
    check("a5.fall_after_ack", 32'(fall_cyc - ack_cyc), 32'd1);
    check_state("a5");
    gap();

    // 0x3C then 0xC3, no ack -> overrun on the second
    send_frame(8'h3C, 1'b1, good_par(8'h3C), -1);
    expect_frame(8'h3C, 1'b1, good_par(8'h3C), 1'b0, 1'b0);
    gap();
    check_state("3c");
    send_frame(8'hC3, 1'b1, good_par(8'hC3), -1);
    expect_frame(8'hC3, 1'b1, good_par(8'hC3), 1'b0, 1'b0);
    gap();
    check_state("c3_overrun");

    // Ack on the completion clk: new byte loaded, valid held, no overrun
    sim_k = lat_meas - 1 - PRE_STOP * BIT_CLK;
    send_frame(8'h5A, 1'b1, good_par(8'h5A), sim_k);
    expect_frame(8'h5A, 1'b1, good_par(8'h5A), 1'b0, 1'b1);
    gap();
    check_state("simul_ack");
    rx_if.data_ack = 1'b1;
    tick_n(1);
    rx_if.data_ack = 1'b0;
    tick_n(1);
    exp_valid = 1'b0;
    check("manual_ack.valid", 32'(rx_if.data_valid), 32'd0);
    rx_if.data_ack = 1'b1;
    tick_n(1);
    rx_if.data_ack = 1'b0;
    tick_n(1);
    check_state("ack_when_idle");

    // 0x55 with stop forced low, then a 200-clk break
    send_frame(8'h55, 1'b0, good_par(8'h55), -1);
    expect_frame(8'h55, 1'b0, good_par(8'h55), 1'b0, 1'b0);
    b0 = busy_hi;
    tick_n(200);
    check("break.busy_cycles", 32'(busy_hi - b0), 32'd0);
    check_state("framing");
    gap();

    // 8-clk glitch on idle line
    b0 = busy_hi;
    FTDI_TX = 1'b0;
    tick_n(8);
    FTDI_TX = 1'b1;
    tick_n(60);
    check("glitch.busy_seen", 32'((busy_hi - b0) != 0), 32'd1);
    check("glitch.busy_end", 32'(rx_if.busy), 32'd0);
    check_state("glitch");

`ifdef FTDI_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 26);
    expect_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    gap();
    check_state("par_bad");
    send_frame(8'h07, 1'b1, 1'b1, -1);
    expect_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
    gap();
    check_state("par_good");
    rx_if.data_ack = 1'b1;
    tick_n(1);
    rx_if.data_ack = 1'b0;
    exp_valid = 1'b0;
    tick_n(2);
`endif

    // Randomized frames against the model
    for (int n = 0; n < 8; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      rp = ($urandom_range(0, 3) == 0) ? ~good_par(rb) : good_par(rb);
      ra = ($urandom_range(0, 1) == 1);
      send_frame(rb, rs, rp, ra ? 28 : -1);
      expect_frame(rb, rs, rp, ra, 1'b0);
      gap();
      check_state($sformatf("rand%0d", n));
    end

    // Leave an unacked byte, then reset in the middle of bit 4 of the next frame
    send_frame(8'h3E, 1'b1, good_par(8'h3E), -1);
    expect_frame(8'h3E, 1'b1, good_par(8'h3E), 1'b0, 1'b0);
    gap();
    check_state("pre_reset");
    FTDI_TX = 1'b0;
    tick_n(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      FTDI_TX = 1'b1;
      tick_n(BIT_CLK);
    end
    FTDI_TX = 1'b0;
    tick_n(BIT_CLK / 2);
    reset = 1'b1;
    tick_n(1);
    check("midreset.busy", 32'(rx_if.busy), 32'd0);
    check("midreset.valid", 32'(rx_if.data_valid), 32'd0);
    reset = 1'b0;
    FTDI_TX = 1'b1;
    exp_data = 8'h00;
    exp_valid = 1'b0;
    tick_n(64);
    check_state("post_reset");

    send_frame(8'h81, 1'b1, good_par(8'h81), -1);
    expect_frame(8'h81, 1'b1, good_par(8'h81), 1'b0, 1'b0);
    diff = rise_cyc - frame_cyc;
    check("81.lat_window", 32'((diff >= LAT - LAT_TOL) && (diff <= LAT + LAT_TOL)), 32'd1);
    gap();
    check_state("81");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
